// File: rtl/pipe_skid_reg.sv
// Two-entry registered pipeline stage (main + skid register) with valid/ready on both sides.
// in_ready comes from a register, so out_ready never reaches it combinationally.
module pipe_skid_reg #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [size-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [size-1:0] out_data,
  input  logic            out_ready,
  output logic [1:0]      count
);

  // Handshake: a word moves on a posedge when valid && ready are both high on that side.
  // The state encoding equals the occupancy, so count doubles as the state debug view.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            r_state;
  logic [size-1:0]   r_main;
  logic [size-1:0]   r_skid;
  logic              r_in_ready;
  logic              r_out_valid;

  logic              w_wf;
  logic              w_rf;

  assign w_wf = in_valid && r_in_ready;
  assign w_rf = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_wf) begin
            r_main      <= in_data;
            r_state     <= FULL;
            r_out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (w_wf && w_rf) begin
            r_main <= in_data;
          end else if (w_rf) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_wf) begin
            // Head is stalled: park the new word and close the input side.
            r_skid     <= in_data;
            r_state    <= SKID;
            r_in_ready <= 1'b0;
          end
        end
        SKID: begin
          if (w_rf) begin
            r_main     <= r_skid;
            r_state    <= FULL;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_state;

endmodule
